// File: rtl/prng_pkg.sv
// Shared definitions for the 24-bit LFSR stream: width, taps, next-word function
// and checker FSM states. Used by both the generator and the checker.
package prng_pkg;

  localparam int PRNG_W = 24;
  localparam int PRNG_N_TAPS = 5;
  localparam int PRNG_TAPS [PRNG_N_TAPS] = '{23, 22, 6, 2, 0};

  function automatic logic [PRNG_W-1:0] tap_mask();
    logic [PRNG_W-1:0] m;
    m = '0;
    for (int i = 0; i < PRNG_N_TAPS; i++) begin
      m[PRNG_TAPS[i]] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [PRNG_W-1:0] PRNG_TAP_MASK = tap_mask();

  // Feedback is the XOR of the tapped bits, shifted in at the MSB.
  function automatic logic [PRNG_W-1:0] lfsr_next(input logic [PRNG_W-1:0] w);
    return {^(w & PRNG_TAP_MASK), w[PRNG_W-1:1]};
  endfunction

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

endpackage

// File: rtl/prng_checker_if.sv
// Stream-in / status-out bundle between a word source and prng_checker.
interface prng_checker_if
  import prng_pkg::*;
#(
  parameter int ERR_W = 16
);
  logic              in_valid;
  logic [PRNG_W-1:0] in_data;
  logic              clr_cnt;
  logic              locked;
  logic              err;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output in_valid, in_data, clr_cnt,
    input  locked, err, err_count
  );

  modport slave (
    input  in_valid, in_data, clr_cnt,
    output locked, err, err_count
  );
endinterface

// File: rtl/prng_checker.sv
// Receive-side LFSR stream checker: self-synchronizing lock FSM, error pulse, saturating count.
// Optional macro PRNG_CHK_ZERO_DET_EN: all-zero words are always mismatches and reset have_prev.
module prng_checker
  import prng_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  prng_checker_if.slave bus
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  chk_state_t        state_q, state_d;
  logic [PRNG_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  cnt_q, cnt_d;

  logic zero_word;
  logic compared;
  logic match;

`ifdef PRNG_CHK_ZERO_DET_EN
  assign zero_word = (bus.in_data == '0);
`else
  assign zero_word = 1'b0;
`endif

  // A word is compared only when a previous word exists, or when it is a forced zero mismatch.
  assign compared = have_prev_q | zero_word;
  assign match    = have_prev_q & ~zero_word & (bus.in_data == lfsr_next(prev_q));

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    if (bus.in_valid) begin
      prev_d      = bus.in_data;
      have_prev_d = ~zero_word;
      if (compared) begin
        if (state_q == SEARCH) begin
          if (match) begin
            if (run_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end else begin
          if (match) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (miss_q + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
              state_d = SEARCH;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
      end
    end

    // Clear beats a coincident increment.
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (err_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      run_q       <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_prng_checker.sv
// Scoreboard bench for prng_checker: two instances (16-bit and 4-bit error counters) share stimulus.
module tb_prng_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int MAX16    = 65535;
  localparam int MAX4     = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prng_checker_if #(.ERR_W(16)) bus16 ();
  prng_checker_if #(.ERR_W(4))  bus4 ();

  assign bus4.in_valid = bus16.in_valid;
  assign bus4.in_data  = bus16.in_data;
  assign bus4.clr_cnt  = bus16.clr_cnt;

  prng_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  prng_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    bit        rst_n;
    bit        valid;
    bit        clr;
    logic [23:0] data;
    bit        locked;
    bit        err;
    int        cnt16;
    int        cnt4;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference next-word: parity of the tapped bits enters at bit 23 while the word shifts right.
  function automatic logic [23:0] ref_next(input logic [23:0] w);
    logic [23:0] taps;
    int par;
    taps = (24'd1 << 23) | (24'd1 << 22) | (24'd1 << 6) | (24'd1 << 2) | 24'd1;
    par  = $countones(w & taps) % 2;
    return (w >> 1) | (24'(par) << 23);
  endfunction

  // Behavioural reference state
  logic [23:0] m_prev;
  bit          m_have;
  bit          m_locked;
  int          m_run;
  int          m_miss;
  int          m_cnt16;
  int          m_cnt4;
  logic [23:0] g;  // last word of the true sequence

  task automatic drive(input bit rst_n, input bit valid, input logic [23:0] data, input bit clr);
    exp_t e;
    bit err;
    bit zero;
    bit is_match;
    @(negedge clk);
    reset          = rst_n;
    bus16.in_valid = valid;
    bus16.in_data  = data;
    bus16.clr_cnt  = clr;
    err = 1'b0;
    if (!rst_n) begin
      m_prev = '0; m_have = 0; m_locked = 0; m_run = 0; m_miss = 0;
      m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (valid) begin
`ifdef PRNG_CHK_ZERO_DET_EN
        zero = (data == 24'd0);
`else
        zero = 1'b0;
`endif
        is_match = m_have && !zero && (data == ref_next(m_prev));
        if (m_have || zero) begin
          if (!m_locked) begin
            m_run = is_match ? m_run + 1 : 0;
            if (m_run == LOCK_CNT) begin
              m_locked = 1; m_run = 0; m_miss = 0;
            end
          end else if (is_match) begin
            m_miss = 0;
          end else begin
            err = 1'b1;
            m_miss++;
            if (m_miss == LOSS_CNT) begin
              m_locked = 0; m_run = 0; m_miss = 0;
            end
          end
        end
        m_prev = data;
        m_have = !zero;
      end
      if (clr) begin
        m_cnt16 = 0;
        m_cnt4  = 0;
      end else if (err) begin
        if (m_cnt16 < MAX16) m_cnt16++;
        if (m_cnt4 < MAX4) m_cnt4++;
      end
    end
    e.rst_n = rst_n; e.valid = valid; e.clr = clr; e.data = data;
    e.locked = m_locked; e.err = err; e.cnt16 = m_cnt16; e.cnt4 = m_cnt4;
    exp_q.push_back(e);
  endtask

  task automatic send_true();
    g = ref_next(g);
    drive(1, 1, g, 0);
  endtask

  task automatic send_wrong(input logic [23:0] flip, input bit clr);
    g = ref_next(g);
    drive(1, 1, g ^ flip, clr);
  endtask

  task automatic idle();
    drive(1, 0, 24'($urandom), 0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      checks += 4;
      if (bus16.locked !== e.locked) begin
        failures++;
        $display("FAIL locked txn=%0d got=%0b exp=%0b", txn, bus16.locked, e.locked);
      end
      if ((bus16.err !== e.err) || (bus4.err !== e.err)) begin
        failures++;
        $display("FAIL err txn=%0d got16=%0b got4=%0b exp=%0b", txn, bus16.err, bus4.err, e.err);
      end
      if (bus16.err_count !== 16'(e.cnt16)) begin
        failures++;
        $display("FAIL err_count16 txn=%0d got=%0d exp=%0d", txn, bus16.err_count, e.cnt16);
      end
      if ((bus4.err_count !== 4'(e.cnt4)) || (bus4.locked !== e.locked)) begin
        failures++;
        $display("FAIL dut4 txn=%0d cnt got=%0d exp=%0d locked got=%0b exp=%0b",
                 txn, bus4.err_count, e.cnt4, bus4.locked, e.locked);
      end
      if (e.valid || !e.rst_n)
        $display("txn %0d rst_n=%0b data=%06h clr=%0b locked=%0b err=%0b cnt16=%0d cnt4=%0d",
                 txn, e.rst_n, e.data, e.clr, bus16.locked, bus16.err,
                 bus16.err_count, bus4.err_count);
    end
  end

  initial begin
    int r;
    reset          = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_data  = '0;
    bus16.clr_cnt  = 1'b0;

    drive(0, 0, 24'd0, 0);
    drive(0, 1, 24'h123456, 1);

    // Lock on the reference vectors 000001, 800000, C00000, 600000, B00000
    g = 24'h000001;
    drive(1, 1, g, 0);
    repeat (4) send_true();
    repeat (5) send_true();

    // Single corrupted word while locked: two errors, lock kept
    send_wrong(24'h000010, 0);
    repeat (6) send_true();

    // Three consecutive wrong words drop lock, then relock
    repeat (3) send_wrong(24'h000100, 0);
    repeat (6) send_true();

    // Correct stream with idle gaps of 1..7 cycles
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 7)) idle();
      send_true();
    end

    // Clear coinciding with a mismatch while locked
    send_wrong(24'h000100, 1);
    repeat (4) send_true();

    // One-cycle reset mid-lock, then relock
    drive(0, 1, 24'($urandom), 0);
    repeat (6) send_true();

    // Constant-zero stream from reset
    drive(0, 0, 24'd0, 0);
    repeat (7) drive(1, 1, 24'd0, 0);
    drive(0, 0, 24'd0, 0);
    g = 24'($urandom_range(1, 24'hFFFFFF));
    drive(1, 1, g, 0);

    // Randomized mix
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 999);
      if (r < 250)       idle();
      else if (r < 310)  send_wrong(24'(1) << $urandom_range(0, 23), 0);
      else if (r < 315)  begin g = ref_next(g); drive(1, 1, g, 1); end
      else if (r < 318)  drive(0, $urandom_range(0, 1), 24'($urandom), 0);
      else if (r < 328)  drive(1, 1, 24'd0, 0);
      else               send_true();
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prng_checker.md
# prng_checker

Receive-side checker for the 24-bit LFSR pseudo-random stream produced by the team's `prng` generator. It samples the generator's word output (or a copy carried across a link) and predicts each word from the previous one. It self-synchronizes to the stream and reports lock status, per-word error pulses and a saturating error count. It sits at the sink end of any datapath or loopback test driven by `prng`.

## Interface
- `LOCK_CNT`, 4: consecutive matching words required to declare lock (≥1).
- `LOSS_CNT`, 3: consecutive mismatches while locked that drop lock (≥1).
- `ERR_W`, 16: width of error counter.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- `in_valid`  in  1  `in_data` holds a stream word this cycle.
- `in_data`  in  24  received LFSR word.
- `clr_cnt`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  checker is locked to the stream.
- `err`  out  1  one-cycle pulse: a word received while locked did not match prediction.
- `err_count`  out  ERR_W  saturating count of `err` pulses.

## Operation
- Next-word function, identical to generator: `fb = w[23]^w[22]^w[6]^w[2]^w[0]`; `next(w) = {fb, w[23:1]}`.
- Internal: `prev[23:0]`, `have_prev`, FSM state, `run` counter (0..LOCK_CNT), `miss` counter (0..LOSS_CNT).
- Only cycles with `in_valid=1` are processed; with `in_valid=0` all state and outputs hold, except that `err` returns to 0. Gaps do not break comparison: consecutive valid words are compared.
- Per valid word: `match = have_prev && (in_data == next(prev))`. Then `prev <= in_data` and `have_prev <= 1`. The checker always reloads from the received word, so it self-resynchronizes.
- First valid word after reset is never compared, never counted and never flagged.
- SEARCH state (`locked=0`):
  - match → `run+1`.
  - When `run` reaches LOCK_CNT → go to LOCKED and clear `run` and `miss`.
  - mismatch → `run=0`.
  - No `err` pulses in SEARCH.
- LOCKED state (`locked=1`):
  - match → `miss=0`.
  - mismatch → `err` pulse and `err_count` increment (saturate at 2^ERR_W−1), then `miss+1`.
  - When `miss` reaches LOSS_CNT → go to SEARCH with `run=0`. The mismatch that causes loss still raises `err`.
- `clr_cnt` clears `err_count` only; it does not affect FSM state, `run` or `miss`. When `clr_cnt` and an increment coincide, clear wins and the result is 0.
- Reset (`reset=0` at an edge, including mid-stream):
  - `locked=0`, `err=0`, `err_count=0`, state SEARCH, `run=0`, `miss=0`, `have_prev=0`, `prev=0`.
  - `reset` has priority over all other inputs.

## Timing
- All outputs are registered.
- `err` is high in the cycle after the edge that samples the offending word, for exactly one cycle per mismatched word.
- `err_count` updates on the same edge as `err`.
- `locked` rises on the edge that accepts the LOCK_CNT-th consecutive match.
- `locked` falls on the edge that accepts the LOSS_CNT-th consecutive mismatch.
- Back-to-back valid words are supported at one per cycle; there is no backpressure.

## Configuration
- `PRNG_CHK_ZERO_DET_EN` defined:
  - An all-zero `in_data` with `in_valid` is always a mismatch, even if the prediction is zero.
  - It does not set `have_prev`; the next nonzero word is loaded without a comparison.
  - A stuck-at-zero line therefore can never lock, and raises `err` every word while locked.
- Not defined: zero words are compared like any other word. A constant-zero stream predicts zero and will lock.

## Structure
- Package `prng_pkg` holds:
  - `PRNG_W = 24` and the tap positions {23,22,6,2,0}.
  - Function `lfsr_next(w)`, also to be adopted by the generator so both ends cannot diverge.
  - FSM state typedef `chk_state_t {SEARCH, LOCKED}`.
- No sub-module: the next-word logic is a package function and the block is one sequential module.

## Test plan
- Reset, then drive valid words 0x000001, 0x800000, 0xC00000, 0x600000, 0xB00000 → `locked` rises after the 5th word (4 matches), `err` never asserted, `err_count=0`.
- Once locked, replace one word with its value XOR 0x000010, then continue the true sequence → at most two `err` pulses (the corrupt word and the following word, predicted from the corrupt one), `err_count=2`, `locked` stays 1 (LOSS_CNT=3).
- Once locked, drive 3 consecutive wrong words → 3 `err` pulses, `locked` falls after the 3rd. Resume the true sequence → relock after 5 valid words.
- Insert `in_valid=0` gaps of 1–7 cycles between the words of a correct stream → behaviour identical to the gapless case, no `err`.
- Assert `clr_cnt` in the same cycle as a mismatch while locked → `err=1` but `err_count=0` next cycle. Force the counter to 0xFFFF, then mismatch → stays 0xFFFF.
- Assert `reset=0` mid-lock for one cycle → all outputs 0. With `PRNG_CHK_ZERO_DET_EN`, a stream of 0x000000 words never locks.
